// File: rtl/vga_console_if.sv
// Producer-side byte stream plus text-buffer write port and cursor of vga_console.
// master = byte producer / observer, slave = the console engine.
`timescale 1ns/1ps
interface vga_console_if;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic [14:0] waddr;
    logic [7:0]  wdata;
    logic        wr_en;
    logic [7:0]  cursor_x;
    logic [5:0]  cursor_y;

    modport master (
        output in_valid, in_char,
        input  in_ready, waddr, wdata, wr_en, cursor_x, cursor_y
    );
    modport slave (
        input  in_valid, in_char,
        output in_ready, waddr, wdata, wr_en, cursor_x, cursor_y
    );
endinterface

// File: rtl/vga_console.sv
// Text console engine: turns an ASCII byte stream into text-buffer writes and a cursor.
// Optional macro VGA_CONSOLE_TAB_EN adds the TAB state (0x09 pads to next 8-column stop).
`timescale 1ns/1ps
module vga_console #(
    parameter int COLS = 160,
    parameter int ROWS = 64
) (
    input  logic        busclk,
    input  logic        rst_n,
    vga_console_if.slave bus
);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
`ifdef VGA_CONSOLE_TAB_EN
        ,TAB       = 2'd3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cur_x_q, cur_x_d;
    logic [5:0]  cur_y_q, cur_y_d;
    logic [7:0]  clr_col_q, clr_col_d;
    logic [5:0]  clr_row_q, clr_row_d;
    logic [14:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_en_q, wr_en_d;

    logic        in_ready;
    logic        accept;
    logic        printable;
    logic [5:0]  next_row;

    // Ready is gated by reset so the producer sees it low for the whole reset window.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = bus.in_valid && in_ready;
    assign printable = (bus.in_char >= 8'h20) && (bus.in_char != 8'h7f);
    assign next_row  = (cur_y_q == LAST_ROW) ? 6'd0 : cur_y_q + 6'd1;

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        wr_en_d = 1'b1;
                        waddr_d = {1'b0, cur_y_q, cur_x_q};
                        wdata_d = bus.in_char;
                        if (cur_x_q == LAST_COL) begin
                            cur_x_d   = 8'd0;
                            cur_y_d   = next_row;
                            clr_col_d = 8'd0;
                            state_d   = CLR_LINE;
                        end else begin
                            cur_x_d = cur_x_q + 8'd1;
                        end
                    end else begin
                        case (bus.in_char)
                            8'h0a: begin
                                cur_x_d   = 8'd0;
                                cur_y_d   = next_row;
                                clr_col_d = 8'd0;
                                state_d   = CLR_LINE;
                            end
                            8'h0d: cur_x_d = 8'd0;
                            8'h08: if (cur_x_q != 8'd0) cur_x_d = cur_x_q - 8'd1;
                            8'h0c: begin
                                clr_col_d = 8'd0;
                                clr_row_d = 6'd0;
                                state_d   = CLR_SCREEN;
                            end
`ifdef VGA_CONSOLE_TAB_EN
                            8'h09: state_d = TAB;
`endif
                            default: ;
                        endcase
                    end
                end
            end
            CLR_LINE: begin
                wr_en_d = 1'b1;
                waddr_d = {1'b0, cur_y_q, clr_col_q};
                wdata_d = 8'h20;
                if (clr_col_q == LAST_COL) state_d = IDLE;
                else clr_col_d = clr_col_q + 8'd1;
            end
            CLR_SCREEN: begin
                wr_en_d = 1'b1;
                waddr_d = {1'b0, clr_row_q, clr_col_q};
                wdata_d = 8'h20;
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = 8'd0;
                    if (clr_row_q == LAST_ROW) begin
                        state_d = IDLE;
                        cur_x_d = 8'd0;
                        cur_y_d = 6'd0;
                    end else begin
                        clr_row_d = clr_row_q + 6'd1;
                    end
                end else begin
                    clr_col_d = clr_col_q + 8'd1;
                end
            end
`ifdef VGA_CONSOLE_TAB_EN
            TAB: begin
                wr_en_d = 1'b1;
                waddr_d = {1'b0, cur_y_q, cur_x_q};
                wdata_d = 8'h20;
                if (cur_x_q == LAST_COL) begin
                    cur_x_d   = 8'd0;
                    cur_y_d   = next_row;
                    clr_col_d = 8'd0;
                    state_d   = CLR_LINE;
                end else begin
                    cur_x_d = cur_x_q + 8'd1;
                    // x+1 lands on a tab stop when the low three bits of x are all ones
                    if (cur_x_q[2:0] == 3'd7) state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge busclk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_x_q   <= 8'd0;
            cur_y_q   <= 6'd0;
            clr_col_q <= 8'd0;
            clr_row_q <= 6'd0;
            waddr_q   <= 15'd0;
            wdata_q   <= 8'd0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.cursor_x = cur_x_q;
    assign bus.cursor_y = cur_y_q;
endmodule

// File: tb/tb_vga_console.sv
// Self-checking bench for vga_console: a console model predicts every buffer write,
// the busy length and the final cursor for each byte sent.
`timescale 1ns/1ps
module tb_vga_console;
    localparam int COLS = 160;
    localparam int ROWS = 64;

    logic busclk = 1'b0;
    logic rst_n  = 1'b0;
    vga_console_if bus();

    vga_console #(.COLS(COLS), .ROWS(ROWS)) dut (
        .busclk (busclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 busclk = ~busclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: cursor position and the writes expected for the current byte.
    int          mx = 0;
    int          my = 0;
    logic [22:0] exp_q[$];
    int          exp_busy;

    function automatic void push_wr(input int r, input int c, input logic [7:0] d);
        exp_q.push_back({1'b0, 6'(r), 8'(c), d});
    endfunction

    function automatic void model_newline();
        mx = 0;
        my = (my + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_wr(my, c, 8'h20);
        exp_busy += COLS;
    endfunction

    function automatic void model_byte(input logic [7:0] ch);
        exp_q.delete();
        exp_busy = 0;
        if ((ch >= 8'h20 && ch <= 8'h7e) || ch >= 8'h80) begin
            push_wr(my, mx, ch);
            mx++;
            if (mx == COLS) model_newline();
        end else if (ch == 8'h0a) begin
            model_newline();
        end else if (ch == 8'h0d) begin
            mx = 0;
        end else if (ch == 8'h08) begin
            if (mx > 0) mx--;
        end else if (ch == 8'h0c) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) push_wr(r, c, 8'h20);
            exp_busy = ROWS * COLS;
            mx = 0;
            my = 0;
        end
`ifdef VGA_CONSOLE_TAB_EN
        else if (ch == 8'h09) begin
            bit done;
            done = 1'b0;
            while (!done) begin
                push_wr(my, mx, 8'h20);
                exp_busy++;
                mx++;
                if (mx == COLS) begin
                    model_newline();
                    done = 1'b1;
                end else if (mx % 8 == 0) begin
                    done = 1'b1;
                end
            end
        end
`endif
    endfunction

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge busclk);
        @(negedge busclk);
        rst_n = 1'b1;
        mx = 0;
        my = 0;
    endtask

    // Send one byte, collect every write until the block is ready again, compare with model.
    task automatic send(input logic [7:0] ch, input string nm);
        int nwr, busy, badcol, bad_idx;
        logic [22:0] got, got_bad, exp_bad;
        bit done;
        nwr = 0; busy = 0; badcol = 0; bad_idx = -1; done = 1'b0;
        got_bad = '0; exp_bad = '0;
        @(negedge busclk);
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: in_ready=%b required 1 before byte %h", nm, bus.in_ready, ch);
        end
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        model_byte(ch);
        @(posedge busclk);
        #1;
        bus.in_valid = 1'b0;
        for (int n = 0; n < ROWS * COLS + 400 && !done; n++) begin
            if (bus.wr_en === 1'b1) begin
                got = {bus.waddr, bus.wdata};
                if (int'(bus.waddr[7:0]) >= COLS) badcol++;
                if (bad_idx < 0 && (nwr >= exp_q.size() || got !== exp_q[nwr])) begin
                    bad_idx = nwr;
                    got_bad = got;
                    exp_bad = (nwr < exp_q.size()) ? exp_q[nwr] : 23'h7fffff;
                end
                nwr++;
            end
            if (bus.in_ready === 1'b1) done = 1'b1;
            else begin
                busy++;
                @(posedge busclk);
                #1;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: in_ready stayed low after byte %h", nm, ch);
        end
        n_chk++;
        if (nwr !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write count: got %0d required %0d (byte %h)", nm, nwr, exp_q.size(), ch);
        end
        n_chk++;
        if (bad_idx >= 0) begin
            n_fail++;
            $display("FAIL %s write #%0d: got addr/data %h/%h required %h/%h", nm, bad_idx,
                     got_bad[22:8], got_bad[7:0], exp_bad[22:8], exp_bad[7:0]);
        end
        n_chk++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d required %0d", nm, busy, exp_busy);
        end
        n_chk++;
        if (badcol !== 0) begin
            n_fail++;
            $display("FAIL %s col range: %0d writes at col>=%0d, required 0", nm, badcol, COLS);
        end
        n_chk++;
        if (int'(bus.cursor_x) !== mx || int'(bus.cursor_y) !== my) begin
            n_fail++;
            $display("FAIL %s cursor: got (%0d,%0d) required (%0d,%0d)", nm,
                     bus.cursor_x, bus.cursor_y, mx, my);
        end
    endtask

    task automatic test_reset();
        do_reset();
        send(8'h51, "reset_pre");
        send(8'h52, "reset_pre");
        @(negedge busclk);
        rst_n = 1'b0;
        repeat (2) @(posedge busclk);
        #1;
        n_chk++;
        if (bus.wr_en !== 1'b0 || bus.waddr !== 15'd0 || bus.wdata !== 8'd0) begin
            n_fail++;
            $display("FAIL reset write port: got wr_en=%b waddr=%h wdata=%h required 0/0000/00",
                     bus.wr_en, bus.waddr, bus.wdata);
        end
        n_chk++;
        if (bus.cursor_x !== 8'd0 || bus.cursor_y !== 6'd0) begin
            n_fail++;
            $display("FAIL reset cursor: got (%0d,%0d) required (0,0)", bus.cursor_x, bus.cursor_y);
        end
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b required 0", bus.in_ready);
        end
        @(negedge busclk);
        rst_n = 1'b1;
        mx = 0;
        my = 0;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset release in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_printable();
        do_reset();
        send(8'h41, "print_A");
        send(8'h80, "print_hi");
        send(8'hff, "print_ff");
        send(8'h7e, "print_7e");
    endtask

    task automatic test_controls();
        logic [7:0] seq [12];
        seq = '{8'h61, 8'h62, 8'h63, 8'h08, 8'h00, 8'h7f, 8'h1b, 8'h0d, 8'h08, 8'h64, 8'h1f, 8'h09};
        do_reset();
        foreach (seq[i]) send(seq[i], "controls");
    endtask

    task automatic test_line_wrap();
        do_reset();
        repeat (5) send(8'h0a, "wrap_lf");
        for (int i = 0; i < COLS - 1; i++) send(8'(8'h61 + i % 26), "wrap_fill");
        send(8'h5a, "wrap_Z");
        n_chk++;
        if (bus.cursor_x !== 8'd0 || bus.cursor_y !== 6'd6) begin
            n_fail++;
            $display("FAIL wrap_Z final cursor: got (%0d,%0d) required (0,6)", bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_row_wrap();
        do_reset();
        repeat (ROWS - 1) send(8'h0a, "rowwrap_lf");
        repeat (3) send(8'h2e, "rowwrap_fill");
        send(8'h0a, "rowwrap_last");
    endtask

    task automatic test_tab();
        do_reset();
        repeat (3) send(8'h2d, "tab_fill");
        send(8'h09, "tab");
        send(8'h09, "tab_again");
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [4];
        s = '{8'h48, 8'h69, 8'h21, 8'h3f};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge busclk);
            n_chk++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b ready %0d: got %b required 1", i, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_char  = s[i];
            model_byte(s[i]);
            @(posedge busclk);
            #1;
            n_chk++;
            if (bus.wr_en !== 1'b1 || {bus.waddr, bus.wdata} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL b2b write %0d: got wr_en=%b %h/%h required 1 %h/%h", i,
                         bus.wr_en, bus.waddr, bus.wdata, exp_q[0][22:8], exp_q[0][7:0]);
            end
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (int'(bus.cursor_x) !== mx) begin
            n_fail++;
            $display("FAIL b2b cursor_x: got %0d required %0d", bus.cursor_x, mx);
        end
    endtask

    task automatic test_form_feed();
        do_reset();
        send(8'h0a, "ff_pre");
        repeat (7) send(8'h23, "ff_pre");
        send(8'h0c, "form_feed");
        send(8'h41, "ff_post");
    endtask

    task automatic test_reset_mid_clear();
        int stray;
        do_reset();
        repeat (5) send(8'h78, "midrst_pre");
        @(negedge busclk);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h0c;
        @(posedge busclk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3000) @(posedge busclk);
        @(negedge busclk);
        rst_n = 1'b0;
        @(posedge busclk);
        #1;
        n_chk++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst wr_en: got %b required 0", bus.wr_en);
        end
        n_chk++;
        if (bus.cursor_x !== 8'd0 || bus.cursor_y !== 6'd0) begin
            n_fail++;
            $display("FAIL midrst cursor: got (%0d,%0d) required (0,0)", bus.cursor_x, bus.cursor_y);
        end
        @(negedge busclk);
        rst_n = 1'b1;
        mx = 0;
        my = 0;
        stray = 0;
        repeat (200) begin
            @(posedge busclk);
            #1;
            if (bus.wr_en !== 1'b0) stray++;
        end
        n_chk++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL midrst stray writes: got %0d required 0", stray);
        end
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        logic [7:0] ch;
        int gap, stray;
        pool = '{8'h0a, 8'h0d, 8'h08, 8'h00, 8'h1b, 8'h7f, 8'h09, 8'h07};
        do_reset();
        for (int i = 0; i < 250; i++) begin
            gap = $urandom_range(0, 2);
            stray = 0;
            repeat (gap) begin
                @(posedge busclk);
                #1;
                if (bus.wr_en !== 1'b0) stray++;
            end
            if (gap > 0) begin
                n_chk++;
                if (stray !== 0) begin
                    n_fail++;
                    $display("FAIL random idle: %0d writes while idle, required 0", stray);
                end
            end
            if ($urandom_range(0, 9) < 7) ch = 8'($urandom_range(32, 255));
            else ch = pool[$urandom_range(0, 7)];
            send(ch, "random");
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        test_reset();
        test_printable();
        test_controls();
        test_line_wrap();
        test_row_wrap();
        test_tab();
        test_back_to_back();
        test_form_feed();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_console.md
VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of busclk.
REQ-002 Parameter COLS, default 160, visible character columns per row (1..256).
REQ-003 Parameter ROWS, default 64, character rows (1..64).
REQ-004 busclk  input  1  bus/system clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  in_char holds a byte to consume.
REQ-007 in_char  input  8  ASCII byte from producer.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 waddr  output  15  text buffer address {row[5:0], col[7:0]}.
REQ-010 wdata  output  8  byte to write into text buffer.
REQ-011 wr_en  output  1  write strobe, one cycle per write.
REQ-012 cursor_x  output  8  current column.
REQ-013 cursor_y  output  6  current row.

Function
REQ-014 A byte SHALL transfer only on a busclk edge where in_valid and in_ready are both high; in_char is sampled on that edge.
REQ-015 States SHALL be IDLE, CLR_LINE, CLR_SCREEN, TAB; in_ready SHALL be high only in IDLE.
REQ-016 waddr, wdata and wr_en SHALL be registered; a write triggered by an accepted byte SHALL appear exactly 1 cycle after acceptance.
REQ-017 Printable byte (0x20..0x7E, 0x80..0xFF): write in_char at {cursor_y, cursor_x}; then cursor_x+1; state stays IDLE.
REQ-018 If cursor_x+1 reaches COLS: cursor_x=0, cursor_y=(cursor_y+1) mod ROWS, enter CLR_LINE.
REQ-019 0x0A (LF): cursor_x=0, cursor_y=(cursor_y+1) mod ROWS, enter CLR_LINE; no write for the LF itself.
REQ-020 CLR_LINE: write 0x20 to columns 0..COLS-1 of the new cursor_y, one per cycle ascending, COLS consecutive wr_en cycles, then return to IDLE.
REQ-021 0x0D (CR): cursor_x=0; no write; stay IDLE.
REQ-022 0x08 (BS): cursor_x decrements if >0, else unchanged; no write; row never changes.
REQ-023 0x0C (FF): enter CLR_SCREEN; write 0x20 to every {row 0..ROWS-1, col 0..COLS-1}, row-major, ROWS*COLS consecutive wr_en cycles; cursor set to (0,0) on exit to IDLE.
REQ-024 Columns COLS..255 SHALL never be written.
REQ-025 All other bytes (0x00..0x1F not listed, 0x7F) SHALL be consumed and ignored: no write, cursor unchanged.
REQ-026 Row wrap: from cursor_y=ROWS-1 the next row is 0; that row is cleared by CLR_LINE (no memory copy/scroll).
REQ-027 wr_en SHALL be low in any cycle not producing a write listed above.
REQ-028 cursor_x/cursor_y SHALL reflect the post-operation position from the cycle after acceptance (for CLR_SCREEN, from exit).

Reset
REQ-029 While rst_n is low at a busclk edge: state=IDLE, cursor_x=0, cursor_y=0, waddr=0, wdata=0, wr_en=0, in_ready=0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-031 Reset during CLR_LINE, CLR_SCREEN or TAB SHALL abort the sweep immediately; no further writes; buffer contents not restored.
REQ-032 Reset SHALL NOT clear the text buffer.

Configuration
REQ-033 Macro VGA_CONSOLE_TAB_EN defined: 0x09 enters TAB, writing 0x20 at the cursor and advancing each cycle until cursor_x is a multiple of 8 (at least one write), then IDLE; reaching COLS wraps per REQ-018.
REQ-034 Macro VGA_CONSOLE_TAB_EN undefined: 0x09 handled per REQ-025; TAB state absent.

Verification
REQ-035 Reset, send 'A'(0x41) -> one cycle later wr_en=1, waddr=0x0000, wdata=0x41; cursor_x=1.
REQ-036 Cursor (159,5), send 'Z' -> write waddr=0x059F; then 160 writes of 0x20 at 0x0600..0x069F, in_ready low exactly those 160 cycles; cursor (0,6).
REQ-037 Cursor (3,63), send 0x0A -> cursor (0,0); row 0 cleared at 0x0000..0x009F.
REQ-038 Send 0x0C -> 10240 consecutive writes of 0x20, no address with col>=160; cursor (0,0); in_ready returns high.
REQ-039 TAB_EN defined, cursor (3,0), send 0x09 -> 5 writes at 0x0003..0x0007, cursor_x=8; undefined -> no write, cursor_x=3.
REQ-040 Assert rst_n low mid-CLR_SCREEN -> wr_en=0 next cycle, cursor (0,0), no further writes after release.
